input_interface: RTL and testbench

Rank-order input encoder at the front of the SNN accelerator. Captures a full image on a one-cycle `NEW_IMAGE` strobe and sorts the pixels by descending intensity. It then emits one AER event per non-zero pixel, brightest first, over a 4-phase REQ/ACK link into the core's `AERIN` port. A `FIRST_INFERENCE_DONE` stop input ends the emission early.

---
 rtl/input_interface_pkg.sv | 34 +++
 rtl/pixel_sorter.sv | 120 ++++++++++++
 rtl/input_interface.sv | 181 ++++++++++++++++++
 tb/tb_input_interface.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_interface_pkg.sv
// Shared types and constants for the rank-order input encoder.
//   state_e       : encoder FSM states (sorting phases plus AER handshake)
//   AER_ADDR_W    : width of the AERIN address bus
//   *_DEF         : default image geometry used by the modules' parameters
//   bin_w, cnt_w  : derived widths for histogram bins / event counts and walk counters
package input_interface_pkg;

    localparam int unsigned AER_ADDR_W          = 10;
    localparam int unsigned IMAGE_SIZE_DEF      = 256;
    localparam int unsigned PIXEL_MAX_VALUE_DEF = 255;
    localparam int unsigned INDEX_W_DEF         = $clog2(IMAGE_SIZE_DEF);
    localparam int unsigned PIXEL_W_DEF         = $clog2(PIXEL_MAX_VALUE_DEF);

    typedef enum logic [2:0] {
        StIdle,
        StHist,
        StPrefix,
        StPlace,
        StSend,
        StWaitAckHi,
        StWaitAckLo
    } state_e;

    // A bin (and the event count) must hold IMAGE_SIZE itself, hence one extra bit.
    function automatic int unsigned bin_w(input int unsigned index_w);
        return index_w + 1;
    endfunction

    // Walk counter covers both the pixel-index walk and the intensity walk.
    function automatic int unsigned cnt_w(input int unsigned index_w, input int unsigned pixel_w);
        return (index_w > pixel_w) ? index_w : pixel_w;
    endfunction

endpackage

// File: rtl/pixel_sorter.sv
// Counting sort of pixel indices by descending intensity (stable on ties).
// Driven by the encoder FSM state:
//   StHist   : histogram of intensities, one pixel per cycle
//   StPrefix : offset[v] = number of pixels brighter than v, walking v from max down to 0
//   StPlace  : scatter each index to sorted[offset[p]++], one pixel per cycle
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   state           : current encoder state
//   clear           : new image accepted; clears histogram and walk state
//   pixels          : captured image
//   step_last       : last step of the current phase
//   sort_done       : last step of StPlace
//   n_events        : number of non-zero pixels (valid from end of StPlace)
//   rd_idx, rd_data : registered read port of the sorted-index RAM (1 cycle latency)
module pixel_sorter
    import input_interface_pkg::*;
#(
    parameter int unsigned IMAGE_SIZE      = IMAGE_SIZE_DEF,
    parameter int unsigned IMAGE_SIZE_BITS = INDEX_W_DEF,
    parameter int unsigned PIXEL_MAX_VALUE = PIXEL_MAX_VALUE_DEF,
    parameter int unsigned PIXEL_BITS      = PIXEL_W_DEF,
    localparam int unsigned BinW           = bin_w(IMAGE_SIZE_BITS),
    localparam int unsigned CntW           = cnt_w(IMAGE_SIZE_BITS, PIXEL_BITS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  state_e                     state,
    input  logic                       clear,
    input  logic [PIXEL_BITS-1:0]      pixels [0:IMAGE_SIZE-1],
    output logic                       step_last,
    output logic                       sort_done,
    output logic [BinW-1:0]            n_events,
    input  logic [IMAGE_SIZE_BITS-1:0] rd_idx,
    output logic [IMAGE_SIZE_BITS-1:0] rd_data
);

    logic [BinW-1:0]            hist   [0:PIXEL_MAX_VALUE];
    logic [BinW-1:0]            offset [0:PIXEL_MAX_VALUE];
    logic [IMAGE_SIZE_BITS-1:0] sorted [0:IMAGE_SIZE-1];

    logic [CntW-1:0]            cnt_q;
    logic [BinW-1:0]            acc_q;
    logic [BinW-1:0]            n_events_q;
    logic [IMAGE_SIZE_BITS-1:0] rd_q;

    logic [IMAGE_SIZE_BITS-1:0] idx;
    logic [PIXEL_BITS-1:0]      pix;
    logic [PIXEL_BITS-1:0]      v;
    logic                       walking;

    assign idx     = cnt_q[IMAGE_SIZE_BITS-1:0];
    assign pix     = pixels[idx];
    assign v       = PIXEL_BITS'(PIXEL_MAX_VALUE) - cnt_q[PIXEL_BITS-1:0];
    assign walking = (state == StHist) || (state == StPrefix) || (state == StPlace);

    always_comb begin
        step_last = 1'b0;
        case (state)
            StHist, StPlace: step_last = (cnt_q == CntW'(IMAGE_SIZE - 1));
            StPrefix:        step_last = (cnt_q == CntW'(PIXEL_MAX_VALUE));
            default:         step_last = 1'b0;
        endcase
    end

    assign sort_done = (state == StPlace) && step_last;
    assign n_events  = n_events_q;
    assign rd_data   = rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            n_events_q <= '0;
        end else begin
            if (clear || !walking || step_last) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (clear) begin
                acc_q <= '0;
            end else if (state == StPrefix) begin
                acc_q <= acc_q + hist[v];
            end

            if (state == StPlace) begin
                n_events_q <= BinW'(IMAGE_SIZE) - hist[0];
            end
        end
    end

    // Storage arrays need no reset: hist is cleared on image capture and offset/sorted
    // are fully rewritten before they are read.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int b = 0; b <= int'(PIXEL_MAX_VALUE); b++) begin
                hist[b] <= '0;
            end
        end else if (state == StHist) begin
            hist[pix] <= hist[pix] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == StPrefix) begin
            offset[v] <= acc_q;
        end else if (state == StPlace) begin
            offset[pix] <= offset[pix] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == StPlace) begin
            sorted[offset[pix][IMAGE_SIZE_BITS-1:0]] <= idx;
        end
        rd_q <= sorted[rd_idx];
    end

endmodule

// File: rtl/input_interface.sv
// Rank-order input encoder: captures an image on NEW_IMAGE, sorts pixels by descending
// intensity and emits one AER event per non-zero pixel, brightest first, over a 4-phase
// REQ/ACK link. FIRST_INFERENCE_DONE ends emission at the next handshake boundary.
// Ports:
//   CLK, RST             : clock, asynchronous active-low reset
//   IMAGE, NEW_IMAGE     : image bus and one-cycle capture strobe (honoured only when idle)
//   FIRST_INFERENCE_DONE : stop request
//   ENCODER_RDY          : idle and ready for a new image
//   AERIN_ADDR/REQ/ACK   : AER output link
// Build option: define AER_ACK_SYNC_EN to pass AERIN_ACK through a 2-flop synchronizer;
// otherwise ACK is used directly (same-clock receiver only).
module input_interface
    import input_interface_pkg::*;
#(
    parameter int unsigned IMAGE_SIZE      = IMAGE_SIZE_DEF,
    parameter int unsigned IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int unsigned PIXEL_MAX_VALUE = PIXEL_MAX_VALUE_DEF,
    parameter int unsigned PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PIXEL_BITS-1:0] IMAGE [0:IMAGE_SIZE-1],
    input  logic                  NEW_IMAGE,
    input  logic                  FIRST_INFERENCE_DONE,
    output logic                  ENCODER_RDY,
    output logic [AER_ADDR_W-1:0] AERIN_ADDR,
    output logic                  AERIN_REQ,
    input  logic                  AERIN_ACK
);

    localparam int unsigned BinW = bin_w(IMAGE_SIZE_BITS);

    state_e                     state_q;
    logic                       rdy_q;
    logic                       req_q;
    logic [AER_ADDR_W-1:0]      addr_q;
    logic [BinW-1:0]            k_q;
    logic                       fetch_q;
    logic [PIXEL_BITS-1:0]      pixel_q [0:IMAGE_SIZE-1];

    logic                       accept;
    logic                       ack_s;
    logic                       step_last;
    logic                       sort_done;
    logic [BinW-1:0]            n_events;
    logic [IMAGE_SIZE_BITS-1:0] rd_data;
    logic [BinW-1:0]            k_next;

    assign accept = (state_q == StIdle) && NEW_IMAGE;
    assign k_next = k_q + 1'b1;

`ifdef AER_ACK_SYNC_EN
    logic [1:0] ack_sync_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[0], AERIN_ACK};
        end
    end

    assign ack_s = ack_sync_q[1];
`else
    assign ack_s = AERIN_ACK;
`endif

    always_ff @(posedge CLK) begin
        if (accept) begin
            pixel_q <= IMAGE;
        end
    end

    pixel_sorter #(
        .IMAGE_SIZE      (IMAGE_SIZE),
        .IMAGE_SIZE_BITS (IMAGE_SIZE_BITS),
        .PIXEL_MAX_VALUE (PIXEL_MAX_VALUE),
        .PIXEL_BITS      (PIXEL_BITS)
    ) u_pixel_sorter (
        .clk       (CLK),
        .rst_n     (RST),
        .state     (state_q),
        .clear     (accept),
        .pixels    (pixel_q),
        .step_last (step_last),
        .sort_done (sort_done),
        .n_events  (n_events),
        .rd_idx    (k_q[IMAGE_SIZE_BITS-1:0]),
        .rd_data   (rd_data)
    );

    // SEND spends its first cycle letting the registered sorted[k] read settle, so the
    // address launched with REQ always belongs to the current k.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            rdy_q   <= 1'b1;
            req_q   <= 1'b0;
            addr_q  <= '0;
            k_q     <= '0;
            fetch_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (NEW_IMAGE) begin
                        state_q <= StHist;
                        rdy_q   <= 1'b0;
                        k_q     <= '0;
                    end
                end
                StHist: begin
                    if (FIRST_INFERENCE_DONE) begin
                        state_q <= StIdle;
                        rdy_q   <= 1'b1;
                    end else if (step_last) begin
                        state_q <= StPrefix;
                    end
                end
                StPrefix: begin
                    if (FIRST_INFERENCE_DONE) begin
                        state_q <= StIdle;
                        rdy_q   <= 1'b1;
                    end else if (step_last) begin
                        state_q <= StPlace;
                    end
                end
                StPlace: begin
                    if (FIRST_INFERENCE_DONE) begin
                        state_q <= StIdle;
                        rdy_q   <= 1'b1;
                    end else if (sort_done) begin
                        state_q <= StSend;
                        fetch_q <= 1'b0;
                    end
                end
                StSend: begin
                    if (!fetch_q) begin
                        fetch_q <= 1'b1;
                    end else begin
                        fetch_q <= 1'b0;
                        if ((n_events == '0) || FIRST_INFERENCE_DONE) begin
                            state_q <= StIdle;
                            rdy_q   <= 1'b1;
                        end else begin
                            addr_q  <= AER_ADDR_W'(rd_data);
                            req_q   <= 1'b1;
                            state_q <= StWaitAckHi;
                        end
                    end
                end
                StWaitAckHi: begin
                    if (ack_s) begin
                        req_q   <= 1'b0;
                        state_q <= StWaitAckLo;
                    end
                end
                StWaitAckLo: begin
                    if (!ack_s) begin
                        k_q <= k_next;
                        if ((k_next == n_events) || FIRST_INFERENCE_DONE) begin
                            state_q <= StIdle;
                            rdy_q   <= 1'b1;
                        end else begin
                            state_q <= StSend;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    rdy_q   <= 1'b1;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ENCODER_RDY = rdy_q;
    assign AERIN_REQ   = req_q;
    assign AERIN_ADDR  = addr_q;

endmodule

// File: tb/tb_input_interface.sv
module tb_input_interface;

    localparam int LAT = 3 * 256 + 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] image [0:255];
    logic       new_image;
    logic       fid;
    logic       rdy;
    logic [9:0] addr;
    logic       req;
    logic       ack;

    int n_checks = 0;
    int n_pass   = 0;
    int events[$];
    int exp_q[$];
    int ref_img[256];
    int held_addr;
    bit req_prev;

    always #5 clk = ~clk;

    input_interface dut (
        .CLK                  (clk),
        .RST                  (rst_n),
        .IMAGE                (image),
        .NEW_IMAGE            (new_image),
        .FIRST_INFERENCE_DONE (fid),
        .ENCODER_RDY          (rdy),
        .AERIN_ADDR           (addr),
        .AERIN_REQ            (req),
        .AERIN_ACK            (ack)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int ev_at(input int i);
        if (i >= 0 && i < events.size()) return events[i];
        return -1;
    endfunction

    // Receiver: acknowledges each phase ~100 ns later.
    initial begin
        ack = 1'b0;
        forever begin
            wait (req === 1'b1);
            #103 ack = 1'b1;
            wait (req === 1'b0);
            #103 ack = 1'b0;
        end
    end

    // Event monitor and link rules.
    always @(negedge clk) begin
        if (!rst_n) begin
            req_prev = 1'b0;
        end else begin
            if (req && !req_prev) begin
                check("req_rise_ack_low", int'(ack), 0);
                events.push_back(int'(addr));
                held_addr = int'(addr);
            end
            if (!req && req_prev) check("addr_hold", int'(addr), held_addr);
            req_prev = req;
        end
    end

    // Reference: brightest first, ties by ascending index, zeros dropped.
    task automatic build_model();
        exp_q.delete();
        for (int v = 255; v >= 1; v--)
            for (int i = 0; i < 256; i++)
                if (ref_img[i] == v) exp_q.push_back(i);
    endtask

    task automatic start(input string tag);
        int lat;
        lat = -1;
        events.delete();
        build_model();
        @(negedge clk);
        for (int i = 0; i < 256; i++) image[i] = 8'(ref_img[i]);
        new_image = 1'b1;
        @(posedge clk);
        #1;
        new_image = 1'b0;
        for (int i = 0; i < 256; i++) image[i] = 8'($urandom);
        check({tag, "_rdy_fall"}, int'(rdy), 0);
        for (int i = 1; i <= 2000; i++) begin
            @(posedge clk);
            #1;
            if (req || rdy) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, lat, LAT);
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, int'(ok), 1);
    endtask

    task automatic wait_events(input string tag, input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (events.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_reached"}, int'(ok), 1);
    endtask

    task automatic compare(input string tag);
        int mism;
        mism = 0;
        check({tag, "_count"}, events.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (ev_at(i) != exp_q[i]) mism++;
        check({tag, "_order_mismatches"}, mism, 0);
    endtask

    task automatic fill_random(input int lo, input int hi);
        for (int i = 0; i < 256; i++) ref_img[i] = int'($urandom_range(hi, lo));
    endtask

    initial begin
        int ones[$];
        int mism;
        int base;
        bit ok;

        rst_n     = 1'b0;
        new_image = 1'b0;
        fid       = 1'b0;
        for (int i = 0; i < 256; i++) image[i] = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_rdy", int'(rdy), 1);
        check("reset_req", int'(req), 0);
        check("reset_addr", int'(addr), 0);

        // Digit-like image
        for (int i = 0; i < 256; i++) ref_img[i] = 0;
        for (int n = 0; n < 20; n++) ref_img[$urandom_range(255, 100)] = int'($urandom_range(200, 2));
        ref_img[10]  = 1;
        ref_img[200] = 1;
        ref_img[73]  = 244;
        ref_img[88]  = 243;
        ref_img[89]  = 239;
        ref_img[56]  = 3;
        ref_img[57]  = 32;
        ref_img[58]  = 81;
        ref_img[59]  = 1;
        start("digit");
        wait_idle("digit");
        compare("digit");
        check("digit_first0", ev_at(0), 73);
        check("digit_first1", ev_at(1), 88);
        check("digit_first2", ev_at(2), 89);
        ones.delete();
        for (int i = 0; i < 256; i++) if (ref_img[i] == 1) ones.push_back(i);
        base = events.size() - ones.size();
        mism = 0;
        for (int i = 0; i < ones.size(); i++) if (ev_at(base + i) != ones[i]) mism++;
        check("digit_tail_value1_mismatches", mism, 0);
        ok = 1'b0;
        for (int i = 0; i < ones.size(); i++) if (ev_at(base + i) == 59) ok = 1'b1;
        check("digit_tail_has_59", int'(ok), 1);

        // All ties
        for (int i = 0; i < 256; i++) ref_img[i] = 7;
        start("ties");
        wait_idle("ties");
        compare("ties");
        check("ties_last", ev_at(255), 255);

        // All zero
        for (int i = 0; i < 256; i++) ref_img[i] = 0;
        start("zero");
        check("zero_rdy_back", int'(rdy), 1);
        repeat (20) @(negedge clk);
        check("zero_no_events", events.size(), 0);

        // Random images, dense ties and zeros
        for (int r = 0; r < 2; r++) begin
            fill_random(0, 15);
            start("rand");
            wait_idle("rand");
            compare("rand");
        end

        // Stop mid-handshake
        fill_random(1, 255);
        start("fid");
        wait_events("fid", 3);
        fid = 1'b1;
        wait_idle("fid");
        repeat (30) @(negedge clk);
        check("fid_events", events.size(), 3);
        check("fid_req", int'(req), 0);
        check("fid_rdy", int'(rdy), 1);
        fid = 1'b0;
        @(negedge clk);

        // NEW_IMAGE during emission is ignored
        fill_random(0, 3);
        start("busy");
        wait_events("busy", 10);
        @(negedge clk);
        for (int i = 0; i < 256; i++) image[i] = 8'($urandom_range(255, 200));
        new_image = 1'b1;
        @(negedge clk);
        new_image = 1'b0;
        check("busy_rdy_still_low", int'(rdy), 0);
        wait_idle("busy");
        compare("busy");

        // Reset mid-handshake
        fill_random(1, 255);
        start("rst");
        wait_events("rst", 2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_drop", int'(req), 0);
        check("rst_rdy", int'(rdy), 1);
        check("rst_addr", int'(addr), 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("rst_idle_req", int'(req), 0);
        check("rst_idle_rdy", int'(rdy), 1);
        check("rst_ack_low", int'(ack), 0);

        // Recovery after reset
        for (int i = 0; i < 256; i++) ref_img[i] = 0;
        for (int n = 0; n < 12; n++) ref_img[$urandom_range(255, 0)] = int'($urandom_range(255, 1));
        start("recover");
        wait_idle("recover");
        compare("recover");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
